// File: rtl/sop_pos_sweep_ctrl_pkg.sv
// Shared definitions for the SOP/POS sweep controller: FSM state encoding
// and the vector/counter widths used by the top and its vector counter.
package sop_pos_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

    localparam int NUM_VECTORS = 16;
    localparam int VEC_W       = 4;
    localparam int CNT_W       = 5;

endpackage

// File: rtl/sop_pos_sweep_ctrl_sweep_vec_counter.sv
// Vector counter for the sweep: holds the current 4-bit input vector,
// clears to zero, advances on enable and flags the last vector (15).
module sweep_vec_counter
    import sop_pos_sweep_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [VEC_W-1:0] vec,
    output logic             last
);

    logic [VEC_W-1:0] vec_reg;

    // Clear wins over enable so an abort or a new sweep always restarts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_reg <= '0;
        end else if (clr) begin
            vec_reg <= '0;
        end else if (en) begin
            vec_reg <= vec_reg + 1'b1;
        end
    end

    assign vec  = vec_reg;
    assign last = (vec_reg == VEC_W'(NUM_VECTORS - 1));

endmodule

// File: rtl/sop_pos_sweep_ctrl.sv
// SOP/POS sweep controller: walks the function block through all 16 input
// vectors, holds each for SETTLE_CYCLES cycles, samples f_sop/f_pos and
// accumulates on-set size, mismatch count and the first mismatching vector.
// Optional truth-table capture is enabled by SOP_POS_SWEEP_TT_CAPTURE_EN.
module sop_pos_sweep_ctrl
    import sop_pos_sweep_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        f_sop,
    input  logic        f_pos,
    output logic        x,
    output logic        y,
    output logic        w,
    output logic        z,
    output logic        busy,
    output logic        done,
    output logic [4:0]  ones_count,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_mismatch,
    output logic        mismatch_flag,
    output logic [15:0] truth_table
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    sweep_state_t     state_reg, state_next;
    logic [3:0]       settle_reg;
    logic [VEC_W-1:0] vec;
    logic             vec_last;

    logic             vec_clr;
    logic             vec_en;
    logic             settle_load;
    logic             settle_dec;
    logic             acc_clear;
    logic             sample_en;

    logic [CNT_W-1:0] ones_count_reg;
    logic [CNT_W-1:0] mismatch_count_reg;
    logic [VEC_W-1:0] first_mismatch_reg;
    logic             mismatch_flag_reg;

    sweep_vec_counter u_vec_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (vec_clr),
        .en    (vec_en),
        .vec   (vec),
        .last  (vec_last)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and control strobes; abort overrides everything, including start.
    always_comb begin
        state_next  = state_reg;
        vec_clr     = 1'b0;
        vec_en      = 1'b0;
        settle_load = 1'b0;
        settle_dec  = 1'b0;
        acc_clear   = 1'b0;
        sample_en   = 1'b0;
        if (abort) begin
            state_next = ST_IDLE;
            vec_clr    = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        vec_clr     = 1'b1;
                        settle_load = 1'b1;
                        acc_clear   = 1'b1;
                        state_next  = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (settle_reg <= 4'd1) begin
                        state_next = ST_SAMPLE;
                    end else begin
                        settle_dec = 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    sample_en = 1'b1;
                    if (vec_last) begin
                        state_next = ST_DONE;
                    end else begin
                        vec_en      = 1'b1;
                        settle_load = 1'b1;
                        state_next  = ST_DRIVE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Settle counter: loaded per vector, counts down while the vector is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_reg <= '0;
        end else if (settle_load) begin
            settle_reg <= SETTLE_INIT;
        end else if (settle_dec) begin
            settle_reg <= settle_reg - 1'b1;
        end
    end

    // Result accumulators: cleared on a new sweep, held across abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_count_reg     <= '0;
            mismatch_count_reg <= '0;
            first_mismatch_reg <= '0;
            mismatch_flag_reg  <= 1'b0;
        end else if (acc_clear) begin
            ones_count_reg     <= '0;
            mismatch_count_reg <= '0;
            first_mismatch_reg <= '0;
            mismatch_flag_reg  <= 1'b0;
        end else if (sample_en) begin
            ones_count_reg <= ones_count_reg + CNT_W'(f_sop);
            if (f_sop != f_pos) begin
                mismatch_count_reg <= mismatch_count_reg + 1'b1;
                if (!mismatch_flag_reg) begin
                    first_mismatch_reg <= vec;
                    mismatch_flag_reg  <= 1'b1;
                end
            end
        end
    end

`ifdef SOP_POS_SWEEP_TT_CAPTURE_EN
    logic [NUM_VECTORS-1:0] truth_table_reg;

    // Truth-table capture: one bit of f_sop per vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            truth_table_reg <= '0;
        end else if (acc_clear) begin
            truth_table_reg <= '0;
        end else if (sample_en) begin
            truth_table_reg[vec] <= f_sop;
        end
    end

    assign truth_table = truth_table_reg;
`else
    assign truth_table = 16'h0000;
`endif

    assign {x, y, w, z}   = vec;
    assign busy           = (state_reg == ST_DRIVE) || (state_reg == ST_SAMPLE);
    assign done           = (state_reg == ST_DONE);
    assign ones_count     = ones_count_reg;
    assign mismatch_count = mismatch_count_reg;
    assign first_mismatch = first_mismatch_reg;
    assign mismatch_flag  = mismatch_flag_reg;

endmodule

// File: tb/tb_sop_pos_sweep_ctrl.sv
// Self-checking bench for sop_pos_sweep_ctrl. Two instances (SETTLE_CYCLES=1
// and 3) are driven by a behavioural function block described by two 16-bit
// truth tables; expected results come from popcounts over those tables.
module tb_sop_pos_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_s [2];
    logic        abort_s [2];
    logic [15:0] sop_tt  [2];
    logic [15:0] pos_tt  [2];

    logic [3:0]  vec_o   [2];
    logic        busy_o  [2];
    logic        done_o  [2];
    logic [4:0]  ones_o  [2];
    logic [4:0]  mm_o    [2];
    logic [3:0]  first_o [2];
    logic        flag_o  [2];
    logic [15:0] tt_o    [2];
    logic        fs      [2];
    logic        fp      [2];

    logic x0, y0, w0, z0, x1, y1, w1, z1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign vec_o[0] = {x0, y0, w0, z0};
    assign vec_o[1] = {x1, y1, w1, z1};
    assign fs[0] = sop_tt[0][vec_o[0]];
    assign fp[0] = pos_tt[0][vec_o[0]];
    assign fs[1] = sop_tt[1][vec_o[1]];
    assign fp[1] = pos_tt[1][vec_o[1]];

    sop_pos_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
        .f_sop(fs[0]), .f_pos(fp[0]),
        .x(x0), .y(y0), .w(w0), .z(z0),
        .busy(busy_o[0]), .done(done_o[0]),
        .ones_count(ones_o[0]), .mismatch_count(mm_o[0]),
        .first_mismatch(first_o[0]), .mismatch_flag(flag_o[0]),
        .truth_table(tt_o[0])
    );

    sop_pos_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
        .f_sop(fs[1]), .f_pos(fp[1]),
        .x(x1), .y(y1), .w(w1), .z(z1),
        .busy(busy_o[1]), .done(done_o[1]),
        .ones_count(ones_o[1]), .mismatch_count(mm_o[1]),
        .first_mismatch(first_o[1]), .mismatch_flag(flag_o[1]),
        .truth_table(tt_o[1])
    );

    function automatic int popcnt(input logic [15:0] v);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int lowest_set(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [15:0] expected_tt(input logic [15:0] sop);
`ifdef SOP_POS_SWEEP_TT_CAPTURE_EN
        return sop;
`else
        return 16'h0000 & sop;
`endif
    endfunction

    // Pulse start for one cycle; returns at the negedge after the sampling edge.
    task automatic pulse_start(input int d);
        @(negedge clk);
        start_s[d] = 1'b1;
        @(negedge clk);
        start_s[d] = 1'b0;
    endtask

    // Wait (bounded) until the driven vector equals target.
    task automatic wait_vec(input int d, input logic [3:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (vec_o[d] == target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Full sweep: per-cycle vec/busy/done trace against the timing rule, then results.
    task automatic run_sweep(input int d, input int s, input string name);
        int          total;
        int          bad_k;
        logic [3:0]  exp_vec;
        logic        exp_done;
        logic [15:0] diff;
        total = 16 * (s + 1);
        bad_k = -1;
        pulse_start(d);
        for (int k = 0; k <= total; k++) begin
            if (k > 0) @(negedge clk);
            exp_done = (k == total);
            exp_vec  = exp_done ? 4'd15 : 4'(k / (s + 1));
            if (bad_k < 0 && (done_o[d] !== exp_done || busy_o[d] !== !exp_done ||
                              vec_o[d] !== exp_vec))
                bad_k = k;
        end
        checks++;
        if (bad_k >= 0) begin
            failures++;
            $display("FAIL %s trace: first bad cycle %0d after start (vec=%0d busy=%0b done=%0b), required done exactly at cycle %0d",
                     name, bad_k, vec_o[d], busy_o[d], done_o[d], total);
        end
        diff = sop_tt[d] ^ pos_tt[d];
        checks++;
        if (ones_o[d] !== 5'(popcnt(sop_tt[d])) || mm_o[d] !== 5'(popcnt(diff)) ||
            flag_o[d] !== (diff != 16'h0) ||
            (diff != 16'h0 && first_o[d] !== 4'(lowest_set(diff))) ||
            tt_o[d] !== expected_tt(sop_tt[d])) begin
            failures++;
            $display("FAIL %s results: got ones=%0d mm=%0d flag=%0b first=%0d tt=%h, required ones=%0d mm=%0d flag=%0b first=%0d tt=%h",
                     name, ones_o[d], mm_o[d], flag_o[d], first_o[d], tt_o[d],
                     popcnt(sop_tt[d]), popcnt(diff), diff != 16'h0, lowest_set(diff),
                     expected_tt(sop_tt[d]));
        end else begin
            $display("sweep %s: ones=%0d mm=%0d first=%0d ok", name, ones_o[d], mm_o[d], first_o[d]);
        end
        // Results must remain stable while done is held.
        @(negedge clk);
        checks++;
        if (done_o[d] !== 1'b1 || ones_o[d] !== 5'(popcnt(sop_tt[d]))) begin
            failures++;
            $display("FAIL %s hold: got done=%0b ones=%0d, required done=1 ones=%0d",
                     name, done_o[d], ones_o[d], popcnt(sop_tt[d]));
        end
    endtask

    task automatic check_zero(input int d, input string name);
        checks++;
        if (vec_o[d] !== 4'd0 || busy_o[d] !== 1'b0 || done_o[d] !== 1'b0 ||
            ones_o[d] !== 5'd0 || mm_o[d] !== 5'd0 || first_o[d] !== 4'd0 ||
            flag_o[d] !== 1'b0 || tt_o[d] !== 16'h0) begin
            failures++;
            $display("FAIL %s: got vec=%0d busy=%0b done=%0b ones=%0d mm=%0d first=%0d flag=%0b tt=%h, required all zero",
                     name, vec_o[d], busy_o[d], done_o[d], ones_o[d], mm_o[d], first_o[d], flag_o[d], tt_o[d]);
        end else begin
            $display("%s: all outputs zero", name);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero(0, "reset_s1");
        check_zero(1, "reset_s3");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_zero(0, "post_reset_idle");
    endtask

    task automatic test_identity;
        sop_tt[0] = 16'h0020;
        pos_tt[0] = 16'h0020;
        run_sweep(0, 1, "identity");
    endtask

    task automatic test_injected;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            sop_tt[0][i] = v[3] ^ v[0];
        end
        pos_tt[0] = sop_tt[0] ^ 16'h0200;
        run_sweep(0, 1, "inject_vec9");
    endtask

    task automatic test_all_mismatch;
        sop_tt[0] = 16'hFFFF;
        pos_tt[0] = 16'h0000;
        run_sweep(0, 1, "all_mismatch");
    endtask

    task automatic test_random;
        for (int n = 0; n < 6; n++) begin
            sop_tt[0] = 16'($urandom);
            pos_tt[0] = (n % 2 == 0) ? sop_tt[0] : 16'($urandom);
            run_sweep(0, 1, $sformatf("random_s1_%0d", n));
        end
    endtask

    task automatic test_settle3;
        sop_tt[1] = 16'($urandom);
        pos_tt[1] = sop_tt[1] ^ 16'($urandom);
        run_sweep(1, 3, "random_s3_a");
        sop_tt[1] = 16'hA5C3;
        pos_tt[1] = 16'hA5C3 ^ 16'h8000;
        run_sweep(1, 3, "s3_mismatch_vec15");
    endtask

    task automatic test_abort;
        bit          ok;
        logic [4:0]  held_ones;
        sop_tt[0] = 16'($urandom) | 16'h0001;
        pos_tt[0] = 16'($urandom);
        pulse_start(0);
        wait_vec(0, 4'd3, ok);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (!ok || vec_o[0] !== 4'd4 || busy_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL start_while_busy: got vec=%0d busy=%0b reached3=%0b, required vec=4 busy=1",
                     vec_o[0], busy_o[0], ok);
        end else begin
            $display("start_while_busy: ignored, vec=4");
        end
        wait_vec(0, 4'd6, ok);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        held_ones = 5'(popcnt(sop_tt[0] & 16'h003F));
        checks++;
        if (!ok || busy_o[0] !== 1'b0 || done_o[0] !== 1'b0 || vec_o[0] !== 4'd0 ||
            ones_o[0] !== held_ones ||
            mm_o[0] !== 5'(popcnt((sop_tt[0] ^ pos_tt[0]) & 16'h003F))) begin
            failures++;
            $display("FAIL abort: got busy=%0b done=%0b vec=%0d ones=%0d mm=%0d, required 0/0/0 ones=%0d mm=%0d",
                     busy_o[0], done_o[0], vec_o[0], ones_o[0], mm_o[0], held_ones,
                     popcnt((sop_tt[0] ^ pos_tt[0]) & 16'h003F));
        end else begin
            $display("abort at vec6: idle, ones=%0d held", ones_o[0]);
        end
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o[0] !== 1'b0 || done_o[0] !== 1'b0 || vec_o[0] !== 4'd0 || ones_o[0] !== held_ones) begin
            failures++;
            $display("FAIL start_abort_same: got busy=%0b done=%0b vec=%0d ones=%0d, required 0/0/0 ones=%0d",
                     busy_o[0], done_o[0], vec_o[0], ones_o[0], held_ones);
        end else begin
            $display("start+abort: stayed idle");
        end
    endtask

    task automatic test_reset_mid_sweep;
        bit ok;
        sop_tt[0] = 16'($urandom) | 16'h0001;
        pos_tt[0] = ~sop_tt[0];
        pulse_start(0);
        wait_vec(0, 4'd7, ok);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL reset_mid_sweep: vec 7 never reached");
        end
        check_zero(0, "reset_mid_sweep");
        @(negedge clk);
        rst_n = 1'b1;
        sop_tt[0] = 16'($urandom);
        pos_tt[0] = 16'($urandom);
        run_sweep(0, 1, "after_reset");
    endtask

    task automatic test_back_to_back;
        sop_tt[1] = 16'($urandom);
        pos_tt[1] = sop_tt[1];
        run_sweep(1, 3, "b2b_s3_a");
        sop_tt[1] = 16'($urandom);
        pos_tt[1] = 16'($urandom);
        run_sweep(1, 3, "b2b_s3_b");
    endtask

    initial begin
        start_s[0] = 1'b0; start_s[1] = 1'b0;
        abort_s[0] = 1'b0; abort_s[1] = 1'b0;
        sop_tt[0] = '0; sop_tt[1] = '0;
        pos_tt[0] = '0; pos_tt[1] = '0;
        test_reset;
        test_identity;
        test_injected;
        test_all_mismatch;
        test_random;
        test_settle3;
        test_abort;
        test_reset_mid_sweep;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
